// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor slice.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width  : bit-counter sizing helper, $clog2(width) with a floor of 1
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;

  // The counter only has to reach width-1, so $clog2(width) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor, purely combinational: computes a - b - b_in.
// Ports:
//   a     in  minuend bit
//   b     in  subtrahend bit
//   b_in  in  borrow from the less significant bit
//   diff  out difference bit
//   b_out out borrow to the more significant bit
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : full_subtractor

// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// using a single full_subtractor cell and a borrow flip-flop.
// Handshake: start (accepted when not busy) -> busy for width cycles ->
// single-cycle done pulse as diff/underflow update. Results hold until the
// next operation completes. All outputs are registered.
//
// Parameters:
//   width      operand/result width, >= 2 (default 6)
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   start      in  request a new operation (ignored while busy)
//   a, b       in  minuend / subtrahend, captured on an accepted start
//   busy       out operation in progress
//   done       out one-cycle pulse when diff/underflow update
//   diff       out result register
//   underflow  out final borrow (a < b)
//
// Build option: define SUB_SERIAL_SAT_EN to saturate diff to 0 on underflow.
// ---------------------------------------------------------------------------
module sub_serial
  import sub_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] diff,
  output logic             underflow
);

  localparam int CNT_W = cnt_width(width);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [width-1:0]   r_a_sh;
  logic [width-1:0]   r_b_sh;
  logic [width-1:0]   r_res;
  logic               r_borrow;

  logic               w_d;
  logic               w_borrow_next;
  logic [width-1:0]   w_res_next;
  logic [width-1:0]   w_result;
  logic               w_last;

  full_subtractor u_fs (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .b_in  (r_borrow),
    .diff  (w_d),
    .b_out (w_borrow_next)
  );

  // Result bits enter at the MSB so that after width shifts bit 0 sits at LSB.
  assign w_res_next = {w_d, r_res[width-1:1]};
  assign w_last     = (r_cnt == CNT_W'(width - 1));

`ifdef SUB_SERIAL_SAT_EN
  assign w_result = w_borrow_next ? '0 : w_res_next;
`else
  assign w_result = w_res_next;
`endif

  // NOTE: every register, datapath included, is reset so that an abort
  // leaves no stale operand or borrow behind; state uses <= exclusively so
  // all updates in this block see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_res     <= '0;
      r_borrow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= RUN;
            busy     <= 1'b1;
          end else begin
            r_state  <= IDLE;
            busy     <= 1'b0;
          end
        end

        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            diff      <= w_result;
            underflow <= w_borrow_next;
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_sub_serial
// Self-checking bench for sub_serial (width = 6). Expected results are pushed
// to a scoreboard queue when an operation is started and popped when the DUT
// pulses done. Define SUB_SERIAL_SAT_EN for both RTL and bench to check the
// saturating build.
// ---------------------------------------------------------------------------
module tb_sub_serial;

  localparam int W = 6;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_uf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         uf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  int   cyc      = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  int   done_cyc_q[$];

  sub_serial #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff = x - y;
    e.uf   = (x < y);
`ifdef SUB_SERIAL_SAT_EN
    if (e.uf) e.diff = '0;
`endif
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      check("busy_done_exclusive", {31'b0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done with diff=%0d, expected no done", diff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_diff", {26'b0, diff}, {26'b0, e.diff});
        check("sb_underflow", {31'b0, underflow}, {31'b0, e.uf});
      end
    end
  end

  // Wait (bounded) until done_cnt reaches target; returns 1 on timeout.
  task automatic wait_done(input int target, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // One complete operation with busy-length and latency checks.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] ed, input logic eu);
    int   b0, d0, start_cyc;
    bit   to;
    exp_t e;
    @(negedge clk);
    b0 = busy_cnt;
    d0 = done_cnt;
    a = xa; b = xb; start = 1'b1;
    e.diff = ed; e.uf = eu;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    check("busy_at_start", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0;
    wait_done(d0 + 1, 30, to);
    if (to) begin
      errors++;
      $display("FAIL op_timeout: got no done within 30 cycles, expected one");
    end else begin
      check("busy_cycles", busy_cnt - b0, W);
      check("done_latency", done_cyc_q[$] - start_cyc, W);
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit to;
    int d0, b0, n0;

    // Test-plan operands with hand-derived results.
    vecs[0] = '{a: 6'd45, b: 6'd12, exp_diff: 6'd33, exp_uf: 1'b0};
`ifdef SUB_SERIAL_SAT_EN
    vecs[1] = '{a: 6'd12, b: 6'd45, exp_diff: 6'd0,  exp_uf: 1'b1};
    vecs[4] = '{a: 6'd0,  b: 6'd63, exp_diff: 6'd0,  exp_uf: 1'b1};
    vecs[6] = '{a: 6'd1,  b: 6'd2,  exp_diff: 6'd0,  exp_uf: 1'b1};
`else
    vecs[1] = '{a: 6'd12, b: 6'd45, exp_diff: 6'd31, exp_uf: 1'b1};
    vecs[4] = '{a: 6'd0,  b: 6'd63, exp_diff: 6'd1,  exp_uf: 1'b1};
    vecs[6] = '{a: 6'd1,  b: 6'd2,  exp_diff: 6'd63, exp_uf: 1'b1};
`endif
    vecs[2] = '{a: 6'd0,  b: 6'd0,  exp_diff: 6'd0,  exp_uf: 1'b0};
    vecs[3] = '{a: 6'd63, b: 6'd63, exp_diff: 6'd0,  exp_uf: 1'b0};
    vecs[5] = '{a: 6'd63, b: 6'd0,  exp_diff: 6'd63, exp_uf: 1'b0};
    vecs[7] = '{a: 6'd32, b: 6'd1,  exp_diff: 6'd31, exp_uf: 1'b0};

    // Reset state.
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_diff", {26'b0, diff}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_uf);

    // start pulsed during RUN is ignored.
    @(negedge clk);
    b0 = busy_cnt; d0 = done_cnt;
    a = 6'd20; b = 6'd5; start = 1'b1;
    sb_q.push_back(model(6'd20, 6'd5));
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 6'd1; b = 6'd2;  // sampled at edge N+2
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;                      // sampled at edge N+4
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    wait_done(d0 + 1, 30, to);
    if (to) begin
      errors++;
      $display("FAIL ignore_timeout: got no done, expected one");
    end
    repeat (10) @(posedge clk);
    check("ignore_single_done", done_cnt - d0, 1);
    check("ignore_busy_cycles", busy_cnt - b0, W);
    check("ignore_diff", {26'b0, diff}, 32'd15);

    // Start held high: back-to-back operations every width+1 cycles.
    d0 = done_cnt;
    n0 = done_cyc_q.size();
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] xa, xb;
      xa = W'($urandom_range(0, 63));
      xb = W'($urandom_range(0, 63));
      @(negedge clk);
      a = xa; b = xb; start = 1'b1;
      sb_q.push_back(model(xa, xb));
      @(posedge clk);
      if (k < 3) repeat (W) @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 4, 40, to);
    if (to) begin
      errors++;
      $display("FAIL stream_timeout: got %0d dones, expected 4", done_cnt - d0);
    end else begin
      for (int k = 1; k < 4; k++)
        check("stream_done_spacing", done_cyc_q[n0 + k] - done_cyc_q[n0 + k - 1], W + 1);
    end
    repeat (3) @(posedge clk);

    // Reset during RUN aborts with no done.
    @(negedge clk);
    d0 = done_cnt;
    a = 6'd40; b = 6'd7; start = 1'b1;   // no scoreboard entry: must never complete
    @(negedge clk); start = 1'b0;        // now after the accept edge
    repeat (3) @(negedge clk);           // RUN cycle 3
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_diff", {26'b0, diff}, 32'd0);
    check("abort_underflow", {31'b0, underflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    run_op(6'd9, 6'd4, 6'd5, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sub_serial
